// File: rtl/cmp_branch_seq.sv
// Conditional-branch sequencer: reads two operands, drives the shared comparator, resolves next PC.
// Optional macro CMP_BRANCH_ILLEGAL_EN adds the `illegal` output for cond 6/7.
module cmp_branch_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned RAW   = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       cond,
  input  logic [RAW-1:0]   ra_idx,
  input  logic [RAW-1:0]   rb_idx,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] pc_in,
  output logic [RAW-1:0]   rf_addr,
  input  logic [WIDTH-1:0] rf_data,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  output logic [2:0]       cmp_sel,
  input  logic             cmp_out,
  output logic [WIDTH-1:0] pc_next,
  output logic             pc_load,
  output logic             taken,
  output logic             busy,
`ifdef CMP_BRANCH_ILLEGAL_EN
  output logic             illegal,
`endif
  output logic             done
);

  typedef enum logic [2:0] {StIdle, StRdA, StRdB, StCmp, StRes} state_t;

  state_t           state_q, state_d;
  logic [2:0]       cond_q;
  logic [RAW-1:0]   ra_q, rb_q;
  logic [WIDTH-1:0] target_q, pc_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic             taken_q;
  // Last comparator drive, replayed outside CMP so the shared comparator sees stable inputs.
  logic [WIDTH-1:0] hold_a_q, hold_b_q;
  logic [2:0]       hold_sel_q;
  logic             taken_d;

`ifdef CMP_BRANCH_ILLEGAL_EN
  logic cond_legal;
  assign cond_legal = (cond_q <= 3'd5);
  assign taken_d    = cmp_out & cond_legal;
`else
  assign taken_d    = cmp_out;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cond_q     <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      target_q   <= '0;
      pc_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      taken_q    <= 1'b0;
      hold_a_q   <= '0;
      hold_b_q   <= '0;
      hold_sel_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cond_q   <= cond;
            ra_q     <= ra_idx;
            rb_q     <= rb_idx;
            target_q <= target;
            pc_q     <= pc_in;
          end
        end
        StRdA: opa_q <= rf_data;
        StRdB: opb_q <= rf_data;
        StCmp: begin
          taken_q    <= taken_d;
          hold_a_q   <= opa_q;
          hold_b_q   <= opb_q;
          hold_sel_q <= cond_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    rf_addr = '0;
    cmp_a   = hold_a_q;
    cmp_b   = hold_b_q;
    cmp_sel = hold_sel_q;
    pc_next = '0;
    pc_load = 1'b0;
    done    = 1'b0;
    busy    = 1'b1;
`ifdef CMP_BRANCH_ILLEGAL_EN
    illegal = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        busy    = 1'b0;
        cmp_a   = '0;
        cmp_b   = '0;
        cmp_sel = '0;
        if (start) state_d = StRdA;
      end
      StRdA: begin
        rf_addr = ra_q;
        state_d = StRdB;
      end
      StRdB: begin
        rf_addr = rb_q;
        state_d = StCmp;
      end
      StCmp: begin
        cmp_a   = opa_q;
        cmp_b   = opb_q;
        cmp_sel = cond_q;
        state_d = StRes;
      end
      StRes: begin
        done    = 1'b1;
        pc_load = 1'b1;
        pc_next = taken_q ? target_q : pc_q + WIDTH'(1);
`ifdef CMP_BRANCH_ILLEGAL_EN
        if (!cond_legal) begin
          illegal = 1'b1;
          pc_load = 1'b0;
        end
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign taken = taken_q;

endmodule

// File: doc/cmp_branch_seq.md
Name: cmp_branch_seq

Overview:
Multi-cycle sequencer for conditional-branch instructions. It fetches two operands from the register file, drives the shared magnitude comparator (a, b, 3-bit sel, 1-bit compout), and resolves the next PC. It sits between the instruction decode FSM and the PC register. Decode hands it one branch at a time.

Parameters:
WIDTH, 16, operand / PC / target width
RAW, 3, register-file address width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
cond  input  3  condition: 0 eq, 1 neq, 2 gt, 3 gte, 4 lt, 5 lte; 6/7 are illegal
ra_idx  input  RAW  register index of operand A
rb_idx  input  RAW  register index of operand B
target  input  WIDTH  branch target address
pc_in  input  WIDTH  current PC value
rf_addr  output  RAW  register-file read address
rf_data  input  WIDTH  register-file read data, combinational from rf_addr
cmp_a  output  WIDTH  comparator operand A
cmp_b  output  WIDTH  comparator operand B
cmp_sel  output  3  comparator select
cmp_out  input  1  comparator result, combinational
pc_next  output  WIDTH  next PC value, valid while pc_load=1
pc_load  output  1  one-cycle PC write strobe
taken  output  1  result of the last branch; held until the next start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset value of all registered outputs and internal registers is 0; the state is IDLE.
- Reset takes effect at any time, including mid-sequence. The operation in progress is abandoned, and no pc_load or done is issued for it.
- FSM states are IDLE, RD_A, RD_B, CMP, RES.
  - IDLE: on start=1, register cond, ra_idx, rb_idx, target and pc_in, then go to RD_A. Otherwise stay in IDLE.
  - RD_A: rf_addr=ra_q. Capture rf_data into opa at the edge, then go to RD_B.
  - RD_B: rf_addr=rb_q. Capture rf_data into opb at the edge, then go to CMP.
  - CMP: cmp_a=opa, cmp_b=opb, cmp_sel=cond_q. Capture cmp_out into taken at the edge, then go to RES.
  - RES: pc_load=1 and done=1 for exactly this cycle. pc_next = taken ? target_q : pc_q+1. Then go to IDLE.
- In IDLE, rf_addr, cmp_a, cmp_b and cmp_sel drive 0. In states other than CMP, cmp_* holds its last CMP value.
- Latency: start at edge N gives done/pc_load high during the cycle after edge N+4, i.e. a 5-cycle occupancy including IDLE.
- Back-to-back: start may be asserted in the cycle done is high only if the FSM is in IDLE. RES always returns to IDLE, so the earliest re-accept is the cycle after done. start while busy=1 is ignored and is not queued.
- ra_idx == rb_idx is legal; both reads return the same register.
- pc_q+1 is modulo 2^WIDTH: 16'hFFFF+1 = 16'h0000.
- Inputs are sampled only at start. Changes to cond, target or pc_in during busy have no effect.
- cond 6/7 (macro off): the comparator's default output is 0, so taken=0 and pc_next=pc_q+1.

Optional Feature:
CMP_BRANCH_ILLEGAL_EN
- Defined: adds output `illegal` (1 bit, reset 0). In RES with cond_q ≥ 6, illegal=1 for that cycle, pc_load=0 (PC unchanged), done=1, and taken is forced to 0.
- Not defined: the port is absent, and cond 6/7 behave as not-taken (pc_next=pc_q+1, pc_load=1).

Test Plan:
- R1=16'h0005, R2=16'h0005, cond=0, pc_in=16'h0010, target=16'h0040: start gives done 4 edges later, taken=1, pc_next=16'h0040, pc_load a single-cycle pulse.
- R1=16'h0003, R2=16'h0007, cond=2 (gt): taken=0 and pc_next=16'h0011. Repeat with cond=4 (lt): taken=1 and pc_next=target. Repeat with cond=5 using R1=R2: taken=1.
- pc_in=16'hFFFF, not-taken (cond=1 with equal operands): pc_next=16'h0000.
- A second start pulsed during RD_B is ignored: exactly one done, and busy falls only after RES. A start in the cycle after done is accepted.
- reset asserted asynchronously during CMP: outputs go to 0 immediately and the state is IDLE. No pc_load or done occurs afterward until a new start.
- cond=7, macro off: taken=0, pc_next=pc_in+1, pc_load=1. Macro on: illegal=1, pc_load=0, done=1.
